systolic_drain: RTL and testbench
=================================

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter n, default 16, meaning the bit width of one accumulator word.
REQ-002 SHALL have parameter size, default 4, meaning the array dimension (size x size PEs).
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  the reset, asynchronous and active-low: asserted when 0.
REQ-005 SHALL have port start  input  1  a pulse indicating that array accumulation is complete.
REQ-006 SHALL have port s_in  input  size*size*n  the flattened PE s_out words; word k = row*size+col sits at bits [k*n +: n].
REQ-007 SHALL have port clr_out  output  1  a one-cycle request to clear the array accumulators.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port out_val  output  1  stream valid.
REQ-010 SHALL have port out_rdy  input  1  stream ready.
REQ-011 SHALL have port out_msg  output  n  the stream word.
REQ-012 SHALL have port out_last  output  1  high on the final word of a drain.

Function
REQ-013 SHALL implement the states IDLE, CAPTURE and DRAIN.
REQ-014 SHALL move IDLE->CAPTURE on the edge where start=1; in every other state start SHALL be ignored.
REQ-015 SHALL, in CAPTURE (exactly one cycle), latch all of s_in into a snapshot buffer at the closing edge, assert clr_out=1, clear the word index to 0, and then move to DRAIN.
REQ-016 SHALL assert clr_out only in CAPTURE, so the snapshot holds the pre-clear sums.
REQ-017 SHALL drive out_val=1 throughout DRAIN and out_val=0 in IDLE and CAPTURE.
REQ-018 SHALL drive out_msg as the snapshot word at the current index, in row-major order (row 0 col 0 first).
REQ-019 SHALL advance the index by 1 only on a handshake (out_val && out_rdy).
REQ-020 SHALL hold out_msg and out_last stable while out_val=1 and out_rdy=0.
REQ-021 SHALL assert out_last only when out_val=1 and the index equals size*size-1.
REQ-022 SHALL move DRAIN->IDLE on the handshake of the last word, with busy=0 in the following cycle.
REQ-023 SHALL ignore a start that coincides with the last handshake; a new start is accepted only from IDLE.
REQ-024 SHALL meet a latency of: start at cycle t, clr_out at t+1, first out_val at t+2, last word at t+1+size*size at the earliest with out_rdy held at 1.
REQ-025 SHALL size the index at $clog2(size*size) bits, with no wrap beyond size*size-1.
REQ-026 SHALL leave the snapshot unchanged outside CAPTURE, regardless of changes on s_in.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, index=0, snapshot=0, out_val=0, out_last=0, clr_out=0, busy=0 and out_msg=0, asynchronously.
REQ-028 SHALL, on reset asserted mid-DRAIN, abandon the remaining words; no partial word SHALL be emitted after release.
REQ-029 SHALL come out of reset in IDLE and accept start on the first edge after release.

Structure
REQ-030 SHALL define the state enum type drain_state_t in the shared package systolic_pkg.
REQ-031 SHALL place the snapshot storage and the word-select multiplexer in one sub-module, systolic_drain_buf (ports: capture enable and index in, word out).
REQ-032 SHALL contain no arithmetic apart from the index increment and compare.

Verification
REQ-033 SHALL cover basic drain: size=2, n=16, s_in words {1,2,3,4}, start, out_rdy=1 -> clr_out at t+1; out_msg 1,2,3,4 on t+2..t+5; out_last only with 4; busy low at t+6.
REQ-034 SHALL cover backpressure: out_rdy toggled 0,1,0,0,1... -> each word held stable while out_rdy=0; order 1,2,3,4 preserved; no word dropped or duplicated.
REQ-035 SHALL cover snapshot isolation: s_in changed to all 0xFFFF on the cycle after CAPTURE -> stream still emits 1,2,3,4.
REQ-036 SHALL cover start while busy: start pulsed mid-DRAIN and on the last handshake -> ignored; exactly 4 words are emitted and clr_out pulses once.
REQ-037 SHALL cover reset mid-drain: rst=0 after word 2 -> out_val=0 immediately; after release, a new start drains a fresh snapshot starting at word 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array drain path: FSM state and index sizing.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } drain_state_t;

  // A single-word array still needs a one-bit index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/systolic_drain_buf.sv
// Snapshot of all PE accumulators; loaded only when cap_en is high.
// The output word is a pure mux of the snapshot by idx, with no added latency.
module systolic_drain_buf
  import systolic_pkg::*;
#(
  parameter int n     = 16,
  parameter int words = 16,
  parameter int iw    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_en,
  input  logic [words*n-1:0] s_in,
  input  logic [iw-1:0]      idx,
  output logic [n-1:0]       word
);

  logic [words-1:0][n-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (cap_en) begin
      snap_d = s_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign word = snap_q[idx];

endmodule

// File: rtl/systolic_drain.sv
// Snapshots the array on start, pulses clr_out, then streams words row-major. Latency: clr_out at +1, first word at +2.
// The stream holds its word while out_rdy is low; start is only accepted in IDLE.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int n    = 16,
  parameter int size = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [size*size*n-1:0]  s_in,
  output logic                    clr_out,
  output logic                    busy,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [n-1:0]            out_msg,
  output logic                    out_last
);

  localparam int WORDS = size * size;
  localparam int IW    = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  drain_state_t   state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           capture;
  logic [n-1:0]   word;

  systolic_drain_buf #(
    .n     (n),
    .words (WORDS),
    .iw    (IW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .cap_en (capture),
    .s_in   (s_in),
    .idx    (idx_q),
    .word   (word)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    clr_out  = 1'b0;
    busy     = (state_q != IDLE);
    out_val  = 1'b0;
    out_last = 1'b0;
    out_msg  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Snapshot and clear share an edge, so the buffer sees pre-clear sums.
        capture = 1'b1;
        clr_out = 1'b1;
        idx_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        out_val  = 1'b1;
        out_msg  = word;
        out_last = (idx_q == LAST_IDX);
        if (out_rdy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain (size=2, n=16) with a queue-based scoreboard.
module tb_systolic_drain;

  localparam int N  = 16;
  localparam int SZ = 2;
  localparam int W  = SZ * SZ;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W*N-1:0] s_in;
  logic           clr_out;
  logic           busy;
  logic           out_val;
  logic           out_rdy;
  logic [N-1:0]   out_msg;
  logic           out_last;

  systolic_drain #(.n(N), .size(SZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_in     (s_in),
    .clr_out  (clr_out),
    .busy     (busy),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] msg;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int pops      = 0;
  int clr_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [N-1:0] a, b, c, d);
    s_in = {d, c, b, a};
  endtask

  task automatic push4(input logic [N-1:0] a, b, c, d);
    exp_t e;
    e.last = 1'b0;
    e.msg = a; exp_q.push_back(e);
    e.msg = b; exp_q.push_back(e);
    e.msg = c; exp_q.push_back(e);
    e.msg = d; e.last = 1'b1; exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_msg   = '0;
  logic         prev_last  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (clr_out) clr_cnt++;
      if (prev_stall) begin
        chk("hold_val", 32'(out_val), 32'd1);
        chk("hold_msg", 32'(out_msg), 32'(prev_msg));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_val && out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", out_msg);
        end else begin
          e = exp_q.pop_front();
          pops++;
          if (out_msg !== e.msg || out_last !== e.last) begin
            failures++;
            $display("FAIL word actual=%0h/last=%0b required=%0h/last=%0b",
                     out_msg, out_last, e.msg, e.last);
          end
        end
      end else if (!out_val) begin
        chk("last_without_val", 32'(out_last), 32'd0);
      end
      prev_stall = out_val && !out_rdy;
      prev_msg   = out_msg;
      prev_last  = out_last;
    end
  end

  int pat[5] = '{0, 1, 0, 0, 1};

  initial begin
    int c0, p0;
    bit done;
    rst = 1'b0; start = 1'b0; out_rdy = 1'b0; s_in = '0;

    // Reset state
    #12;
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr_out", 32'(clr_out), 32'd0);
    chk("rst_out_msg", 32'(out_msg), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic drain, out_rdy held high
    set_words(16'd1, 16'd2, 16'd3, 16'd4);
    out_rdy = 1'b1;
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    c0 = clr_cnt; p0 = pops;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("basic_clr_t1", 32'(clr_out), 32'd1);
    chk("basic_busy_t1", 32'(busy), 32'd1);
    chk("basic_val_t1", 32'(out_val), 32'd0);
    tick();
    chk("basic_val_t2", 32'(out_val), 32'd1);
    chk("basic_msg_t2", 32'(out_msg), 32'd1);
    chk("basic_clr_t2", 32'(clr_out), 32'd0);
    tick(); tick();
    chk("basic_last_t4", 32'(out_last), 32'd0);
    tick();
    chk("basic_last_t5", 32'(out_last), 32'd1);
    chk("basic_msg_t5", 32'(out_msg), 32'd4);
    tick();
    chk("basic_busy_t6", 32'(busy), 32'd0);
    chk("basic_val_t6", 32'(out_val), 32'd0);
    chk("basic_clr_count", 32'(clr_cnt - c0), 32'd1);
    chk("basic_word_count", 32'(pops - p0), 32'd4);

    // Backpressure with out_rdy pattern 0,1,0,0,1,...
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    p0 = pops;
    start = 1'b1;
    tick(); start = 1'b0; out_rdy = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
      out_rdy = pat[k % 5] != 0;
    end
    chk("bp_drain_done", 32'(done), 32'd1);
    chk("bp_word_count", 32'(pops - p0), 32'd4);
    out_rdy = 1'b1;

    // Snapshot isolation: s_in changes right after CAPTURE
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    s_in = {W{16'hFFFF}};
    chk("iso_msg_t2", 32'(out_msg), 32'd1);
    tick(); tick(); tick(); tick();
    chk("iso_busy_t6", 32'(busy), 32'd0);
    set_words(16'd1, 16'd2, 16'd3, 16'd4);

    // Start while busy: mid-drain and on the last handshake
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    c0 = clr_cnt; p0 = pops;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    chk("sb_busy_t6", 32'(busy), 32'd0);
    tick();
    chk("sb_busy_t7", 32'(busy), 32'd0);
    chk("sb_clr_t7", 32'(clr_out), 32'd0);
    chk("sb_clr_count", 32'(clr_cnt - c0), 32'd1);
    chk("sb_word_count", 32'(pops - p0), 32'd4);

    // Reset mid-drain after word 2, then a fresh drain
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    p0 = pops;
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("rm_words_before", 32'(pops - p0), 32'd2);
    rst = 1'b0;
    #1;
    chk("rm_val_async", 32'(out_val), 32'd0);
    chk("rm_busy_async", 32'(busy), 32'd0);
    chk("rm_msg_async", 32'(out_msg), 32'd0);
    exp_q.delete();
    tick(); tick();
    set_words(16'd5, 16'd6, 16'd7, 16'd8);
    push4(16'd5, 16'd6, 16'd7, 16'd8);
    rst = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("rm_clr_after_release", 32'(clr_out), 32'd1);
    tick();
    chk("rm_val_t2", 32'(out_val), 32'd1);
    chk("rm_msg_t2", 32'(out_msg), 32'd5);
    tick(); tick(); tick(); tick();
    chk("rm_busy_end", 32'(busy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
